// File: rtl/walker_sequencer.sv
// walker_sequencer: runs i_count single-beat Wishbone writes ("walks") with
// idle gaps between them, stall/ack timeout abort, done pulse and error flag.
// Ports: i_clk, i_reset_n (async low); i_trigger, i_count start a run;
//   o_cyc/o_stb/o_we/o_addr/o_data with i_stall/i_ack/i_data form the
//   pipelined Wishbone master; o_busy, o_done, o_err, o_walks report status.
module walker_sequencer #(
    parameter int STALL_TIMEOUT = 64,
    parameter int GAP           = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_trigger,
    input  logic [3:0] i_count,
    output logic       o_cyc,
    output logic       o_stb,
    output logic       o_we,
    output logic       o_addr,
    output logic [5:0] o_data,
    input  logic       i_stall,
    input  logic       i_ack,
    input  logic [5:0] i_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [3:0] o_walks
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_ACKWAIT,
        S_GAP
    } state_t;

    localparam int TW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(STALL_TIMEOUT - 1);
    localparam logic [7:0] G_LAST = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

    state_t        state, state_n;
    logic [3:0]    count_q, count_n;
    logic [3:0]    walks_n, walks_inc;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [7:0]    gcnt, gcnt_n;
    logic [5:0]    data_n;
    logic          done_n, err_n;
    logic          unused_data;

    // Read data is never consumed.
    assign unused_data = ^i_data;
    assign o_addr      = 1'b0;
    assign walks_inc   = o_walks + 4'd1;

    always_comb begin
        state_n = state;
        count_n = count_q;
        walks_n = o_walks;
        tcnt_n  = tcnt;
        gcnt_n  = gcnt;
        data_n  = o_data;
        done_n  = 1'b0;
        err_n   = o_err;
        unique case (state)
            S_IDLE: begin
                if (i_trigger) begin
                    walks_n = 4'd0;
                    err_n   = 1'b0;
                    if (i_count != 4'd0) begin
                        count_n = i_count;
                        tcnt_n  = '0;
                        data_n  = 6'd0;
                        state_n = S_WRITE;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (!i_stall) begin
                    tcnt_n  = '0;
                    state_n = S_ACKWAIT;
                end else if (tcnt == T_LAST) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            S_ACKWAIT: begin
                if (i_ack) begin
                    walks_n = walks_inc;
                    if (walks_inc < count_q) begin
                        if (GAP == 0) begin
                            // No gap: keep the cycle open into the next write.
                            tcnt_n  = '0;
                            data_n  = {2'b00, walks_inc};
                            state_n = S_WRITE;
                        end else begin
                            gcnt_n  = 8'd0;
                            state_n = S_GAP;
                        end
                    end else begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end else if (tcnt == T_LAST) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt == G_LAST) begin
                    tcnt_n  = '0;
                    data_n  = {2'b00, o_walks};
                    state_n = S_WRITE;
                end else begin
                    gcnt_n = gcnt + 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Bus/status outputs are registered from the next state so they change
    // on the same edge as the state they describe.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_IDLE;
            count_q <= 4'd0;
            o_walks <= 4'd0;
            tcnt    <= '0;
            gcnt    <= 8'd0;
            o_data  <= 6'd0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_cyc   <= 1'b0;
            o_stb   <= 1'b0;
            o_we    <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_n;
            count_q <= count_n;
            o_walks <= walks_n;
            tcnt    <= tcnt_n;
            gcnt    <= gcnt_n;
            o_data  <= data_n;
            o_done  <= done_n;
            o_err   <= err_n;
            o_cyc   <= (state_n == S_WRITE) || (state_n == S_ACKWAIT);
            o_stb   <= (state_n == S_WRITE);
            o_we    <= (state_n == S_WRITE);
            o_busy  <= (state_n != S_IDLE);
        end
    end

endmodule
